// File: rtl/regfile_checker_if.sv
// Bus bundle between the register-file checker and its processor/regfile/ROM environment.
// The slave modport is the checker side; the master modport is the environment side.
interface regfile_checker_if #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CYCLE_W    = 16
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic                  start;
  logic [CYCLE_W-1:0]    num_cycles;
  logic [IDX_W-1:0]      cpu_rs1;
  logic [IDX_W-1:0]      rs1_out;
  logic [DATA_WIDTH-1:0] reg_data;
  logic [IDX_W-1:0]      exp_addr;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CNT_W-1:0]      err_count;
  logic                  first_err_valid;
  logic [IDX_W-1:0]      first_err_reg;
  logic [DATA_WIDTH-1:0] first_err_act;
  logic [DATA_WIDTH-1:0] first_err_exp;

  modport slave (
    input  start, num_cycles, cpu_rs1, reg_data, exp_data,
    output rs1_out, exp_addr, cpu_hold, busy, done, pass, err_count,
           first_err_valid, first_err_reg, first_err_act, first_err_exp
  );

  modport master (
    output start, num_cycles, cpu_rs1, reg_data, exp_data,
    input  rs1_out, exp_addr, cpu_hold, busy, done, pass, err_count,
           first_err_valid, first_err_reg, first_err_act, first_err_exp
  );
endinterface

// File: rtl/regfile_checker.sv
// Runs the processor for a programmed number of cycles, then scans every register against a ROM.
// Optional first-mismatch capture is enabled by defining REGFILE_CHECKER_FIRST_ERR_EN.
module regfile_checker #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CYCLE_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  regfile_checker_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, RUN, SCAN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [CYCLE_W-1:0]    numCycles_q, numCycles_d;
  logic [CYCLE_W-1:0]    cycle_q, cycle_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      errCount_q, errCount_d;
  logic [DATA_WIDTH-1:0] capData_q;
  logic                  cmpValid_q;
  logic                  startAccept;
  logic                  mismatch;
  logic                  scanning;

  assign startAccept = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign scanning    = (state_q == SCAN) || (state_q == DRAIN);
  // Captured regfile data lines up with ROM data because the ROM has one cycle of latency.
  assign mismatch    = cmpValid_q && (capData_q != bus.exp_data);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      numCycles_q <= '0;
      cycle_q     <= '0;
      idx_q       <= '0;
      errCount_q  <= '0;
      capData_q   <= '0;
      cmpValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      numCycles_q <= numCycles_d;
      cycle_q     <= cycle_d;
      idx_q       <= idx_d;
      errCount_q  <= errCount_d;
      capData_q   <= (state_q == SCAN) ? bus.reg_data : capData_q;
      cmpValid_q  <= (state_q == SCAN);
    end
  end

  always_comb begin
    state_d     = state_q;
    numCycles_d = numCycles_q;
    cycle_d     = cycle_q;
    idx_d       = idx_q;
    errCount_d  = errCount_q;
    if (mismatch) begin
      errCount_d = errCount_q + CNT_W'(1);
    end
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          numCycles_d = bus.num_cycles;
          cycle_d     = '0;
          idx_d       = '0;
          errCount_d  = '0;
          state_d     = (bus.num_cycles == '0) ? SCAN : RUN;
        end
      end
      RUN: begin
        if (cycle_q == numCycles_q - CYCLE_W'(1)) begin
          idx_d   = '0;
          state_d = SCAN;
        end else begin
          cycle_d = cycle_q + CYCLE_W'(1);
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rs1_out   = scanning ? idx_q : bus.cpu_rs1;
  assign bus.exp_addr  = scanning ? idx_q : '0;
  assign bus.cpu_hold  = scanning || (state_q == DONE);
  assign bus.busy      = scanning || (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (errCount_q == '0);
  assign bus.err_count = errCount_q;

`ifdef REGFILE_CHECKER_FIRST_ERR_EN
  logic                  firstValid_q;
  logic [IDX_W-1:0]      firstReg_q;
  logic [DATA_WIDTH-1:0] firstAct_q;
  logic [DATA_WIDTH-1:0] firstExp_q;
  logic [IDX_W-1:0]      cmpIdx_q;

  // Only the earliest mismatch of a run is kept; a new accepted start rearms the capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      firstValid_q <= 1'b0;
      firstReg_q   <= '0;
      firstAct_q   <= '0;
      firstExp_q   <= '0;
      cmpIdx_q     <= '0;
    end else begin
      cmpIdx_q <= idx_q;
      if (startAccept) begin
        firstValid_q <= 1'b0;
        firstReg_q   <= '0;
        firstAct_q   <= '0;
        firstExp_q   <= '0;
      end else if (mismatch && !firstValid_q) begin
        firstValid_q <= 1'b1;
        firstReg_q   <= cmpIdx_q;
        firstAct_q   <= capData_q;
        firstExp_q   <= bus.exp_data;
      end
    end
  end

  assign bus.first_err_valid = firstValid_q;
  assign bus.first_err_reg   = firstReg_q;
  assign bus.first_err_act   = firstAct_q;
  assign bus.first_err_exp   = firstExp_q;
`else
  assign bus.first_err_valid = 1'b0;
  assign bus.first_err_reg   = '0;
  assign bus.first_err_act   = '0;
  assign bus.first_err_exp   = '0;
`endif
endmodule

// File: tb/tb_regfile_checker.sv
// Self-checking bench for regfile_checker: a simple regfile array and synchronous ROM model
// surround the checker, and expected results come from counting differing entries directly.
module tb_regfile_checker;
  localparam int NUM_REGS   = 32;
  localparam int DATA_WIDTH = 32;
  localparam int CYCLE_W    = 16;
  localparam int IDX_W      = 5;
  localparam int CNT_W      = 6;
  localparam int MAX_WAIT   = 2000;

  logic clock = 1'b0;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;

  logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0] expRom [NUM_REGS];

  regfile_checker_if #(.NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH), .CYCLE_W(CYCLE_W)) bus ();

  regfile_checker #(.NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH), .CYCLE_W(CYCLE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  assign bus.reg_data = regs[bus.rs1_out];
  always @(posedge clock) bus.exp_data <= expRom[bus.exp_addr];

  // Reference model: a register fails when its content differs from the ROM entry.
  function automatic int modelErrs();
    int n = 0;
    for (int i = 0; i < NUM_REGS; i++) if (regs[i] != expRom[i]) n++;
    return n;
  endfunction

  task automatic modelFirstErr(output logic v, output logic [IDX_W-1:0] r,
                               output logic [DATA_WIDTH-1:0] a, output logic [DATA_WIDTH-1:0] e);
    v = 1'b0; r = '0; a = '0; e = '0;
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!v && regs[i] != expRom[i]) begin
        v = 1'b1; r = IDX_W'(i); a = regs[i]; e = expRom[i];
      end
    end
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fillMatching();
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[i]   = $urandom;
      expRom[i] = regs[i];
    end
  endtask

  task automatic startRun(input int n);
    bus.num_cycles = CYCLE_W'(n);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Counts observed busy cycles from the current one until busy drops, with a bound.
  task automatic waitDone(output int busyCycles);
    busyCycles = 0;
    while (bus.busy === 1'b1 && busyCycles < MAX_WAIT) begin
      busyCycles++;
      tick();
    end
    if (busyCycles >= MAX_WAIT) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL wait_done: busy still %b after %0d cycles, required 0", bus.busy, busyCycles);
    end
  endtask

  task automatic test_reset();
    logic [IDX_W-1:0] sel;
    reset = 1'b1;
    bus.cpu_rs1 = IDX_W'($urandom);
    tick(); tick();
    testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
    testsRun++; if (bus.pass !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pass: got %b want 0", bus.pass); end
    testsRun++; if (bus.cpu_hold !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_hold: got %b want 0", bus.cpu_hold); end
    testsRun++; if (bus.err_count !== '0) begin testsFailed++; $display("[TB] FAIL reset_err: got %0d want 0", bus.err_count); end
    testsRun++; if (bus.exp_addr !== '0) begin testsFailed++; $display("[TB] FAIL reset_exp_addr: got %0d want 0", bus.exp_addr); end
    testsRun++; if (bus.first_err_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fev: got %b want 0", bus.first_err_valid); end
    testsRun++; if (bus.rs1_out !== bus.cpu_rs1) begin testsFailed++; $display("[TB] FAIL reset_rs1: got %0d want %0d", bus.rs1_out, bus.cpu_rs1); end
    reset = 1'b0;
    tick();
    sel = IDX_W'($urandom);
    bus.cpu_rs1 = sel;
    #1;
    testsRun++; if (bus.rs1_out !== sel) begin testsFailed++; $display("[TB] FAIL idle_rs1: got %0d want %0d", bus.rs1_out, sel); end
  endtask

  task automatic test_all_match();
    int cyc;
    fillMatching();
    startRun(5);
    waitDone(cyc);
    testsRun++; if (cyc !== 5 + NUM_REGS + 1) begin testsFailed++; $display("[TB] FAIL match_busy_len: got %0d want %0d", cyc, 5 + NUM_REGS + 1); end
    testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("[TB] FAIL match_done: got %b want 1", bus.done); end
    testsRun++; if (bus.pass !== 1'b1) begin testsFailed++; $display("[TB] FAIL match_pass: got %b want 1", bus.pass); end
    testsRun++; if (bus.err_count !== '0) begin testsFailed++; $display("[TB] FAIL match_err: got %0d want 0", bus.err_count); end
    testsRun++; if (bus.cpu_hold !== 1'b1) begin testsFailed++; $display("[TB] FAIL match_hold: got %b want 1", bus.cpu_hold); end
  endtask

  task automatic test_two_errors();
    int cyc;
    logic v; logic [IDX_W-1:0] r; logic [DATA_WIDTH-1:0] a, e;
    fillMatching();
    regs[7] = 32'd3;  expRom[7]  = 32'd4;
    regs[20] = 32'd0; expRom[20] = 32'd9;
    startRun($urandom_range(1, 4));
    waitDone(cyc);
    modelFirstErr(v, r, a, e);
    testsRun++; if (bus.err_count !== CNT_W'(modelErrs())) begin testsFailed++; $display("[TB] FAIL two_err_count: got %0d want %0d", bus.err_count, modelErrs()); end
    testsRun++; if (bus.pass !== 1'b0) begin testsFailed++; $display("[TB] FAIL two_err_pass: got %b want 0", bus.pass); end
    testsRun++; if (bus.first_err_valid !== v) begin testsFailed++; $display("[TB] FAIL two_err_fev: got %b want %b", bus.first_err_valid, v); end
    testsRun++; if (bus.first_err_reg !== r) begin testsFailed++; $display("[TB] FAIL two_err_reg: got %0d want %0d", bus.first_err_reg, r); end
    testsRun++; if (bus.first_err_act !== a) begin testsFailed++; $display("[TB] FAIL two_err_act: got %0d want %0d", bus.first_err_act, a); end
    testsRun++; if (bus.first_err_exp !== e) begin testsFailed++; $display("[TB] FAIL two_err_exp: got %0d want %0d", bus.first_err_exp, e); end
  endtask

  task automatic test_zero_cycles();
    int cyc;
    fillMatching();
    bus.cpu_rs1 = IDX_W'(13);
    startRun(0);
    testsRun++; if (bus.rs1_out !== '0) begin testsFailed++; $display("[TB] FAIL zero_rs1_first: got %0d want 0", bus.rs1_out); end
    testsRun++; if (bus.cpu_hold !== 1'b1) begin testsFailed++; $display("[TB] FAIL zero_hold: got %b want 1", bus.cpu_hold); end
    tick();
    testsRun++; if (bus.rs1_out !== IDX_W'(1)) begin testsFailed++; $display("[TB] FAIL zero_rs1_second: got %0d want 1", bus.rs1_out); end
    testsRun++; if (bus.exp_addr !== IDX_W'(1)) begin testsFailed++; $display("[TB] FAIL zero_exp_addr: got %0d want 1", bus.exp_addr); end
    waitDone(cyc);
    testsRun++; if (cyc !== NUM_REGS) begin testsFailed++; $display("[TB] FAIL zero_busy_len: got %0d want %0d", cyc, NUM_REGS); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc, guard;
    fillMatching();
    regs[2] = ~expRom[2];
    bus.cpu_rs1 = '0;
    startRun(3);
    guard = 0;
    while (!(bus.cpu_hold === 1'b1 && bus.rs1_out === IDX_W'(10)) && guard < MAX_WAIT) begin
      guard++;
      tick();
    end
    testsRun++; if (bus.err_count !== CNT_W'(1)) begin testsFailed++; $display("[TB] FAIL midscan_err_before: got %0d want 1", bus.err_count); end
    #2 reset = 1'b1;
    #1;
    testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midscan_busy: got %b want 0", bus.busy); end
    testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL midscan_done: got %b want 0", bus.done); end
    testsRun++; if (bus.err_count !== '0) begin testsFailed++; $display("[TB] FAIL midscan_err: got %0d want 0", bus.err_count); end
    testsRun++; if (bus.rs1_out !== bus.cpu_rs1) begin testsFailed++; $display("[TB] FAIL midscan_rs1: got %0d want %0d", bus.rs1_out, bus.cpu_rs1); end
    #1 reset = 1'b0;
    tick();
    startRun(0);
    testsRun++; if (bus.rs1_out !== '0) begin testsFailed++; $display("[TB] FAIL rescan_rs1: got %0d want 0", bus.rs1_out); end
    waitDone(cyc);
    testsRun++; if (cyc !== NUM_REGS + 1) begin testsFailed++; $display("[TB] FAIL rescan_len: got %0d want %0d", cyc, NUM_REGS + 1); end
    testsRun++; if (bus.err_count !== CNT_W'(modelErrs())) begin testsFailed++; $display("[TB] FAIL rescan_err: got %0d want %0d", bus.err_count, modelErrs()); end
  endtask

  task automatic test_start_handling();
    int cyc;
    fillMatching();
    regs[5] = ~expRom[5];
    startRun(6);
    tick(); tick();
    bus.num_cycles = CYCLE_W'(20);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    waitDone(cyc);
    testsRun++; if (cyc + 3 !== 6 + NUM_REGS + 1) begin testsFailed++; $display("[TB] FAIL ignore_start_len: got %0d want %0d", cyc + 3, 6 + NUM_REGS + 1); end
    testsRun++; if (bus.err_count !== CNT_W'(modelErrs())) begin testsFailed++; $display("[TB] FAIL ignore_start_err: got %0d want %0d", bus.err_count, modelErrs()); end
    startRun(2);
    testsRun++; if (bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL restart_busy: got %b want 1", bus.busy); end
    testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_done: got %b want 0", bus.done); end
    testsRun++; if (bus.err_count !== '0) begin testsFailed++; $display("[TB] FAIL restart_err_clear: got %0d want 0", bus.err_count); end
    testsRun++; if (bus.first_err_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_fev: got %b want 0", bus.first_err_valid); end
    waitDone(cyc);
    testsRun++; if (cyc !== 2 + NUM_REGS + 1) begin testsFailed++; $display("[TB] FAIL restart_len: got %0d want %0d", cyc, 2 + NUM_REGS + 1); end
  endtask

  task automatic test_last_reg();
    fillMatching();
    regs[NUM_REGS-1] = regs[NUM_REGS-1] ^ 32'h1;
    startRun(0);
    for (int i = 0; i < NUM_REGS; i++) tick();
    testsRun++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_state: busy %b done %b want busy 1 done 0", bus.busy, bus.done); end
    testsRun++; if (bus.rs1_out !== IDX_W'(NUM_REGS-1)) begin testsFailed++; $display("[TB] FAIL drain_rs1: got %0d want %0d", bus.rs1_out, NUM_REGS-1); end
    testsRun++; if (bus.err_count !== '0) begin testsFailed++; $display("[TB] FAIL drain_err: got %0d want 0", bus.err_count); end
    tick();
    testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("[TB] FAIL last_done: got %b want 1", bus.done); end
    testsRun++; if (bus.err_count !== CNT_W'(1)) begin testsFailed++; $display("[TB] FAIL last_err: got %0d want 1", bus.err_count); end
    testsRun++; if (bus.pass !== 1'b0) begin testsFailed++; $display("[TB] FAIL last_pass: got %b want 0", bus.pass); end
  endtask

  task automatic test_random();
    int cyc, n, k, errs;
    logic v; logic [IDX_W-1:0] r; logic [DATA_WIDTH-1:0] a, e;
    for (int it = 0; it < 8; it++) begin
      fillMatching();
      k = $urandom_range(0, 5);
      for (int j = 0; j < k; j++) begin
        int idx = $urandom_range(0, NUM_REGS - 1);
        regs[idx] = expRom[idx] ^ ($urandom | 32'h1);
      end
      n = $urandom_range(0, 7);
      bus.cpu_rs1 = IDX_W'($urandom);
      startRun(n);
      waitDone(cyc);
      errs = modelErrs();
      modelFirstErr(v, r, a, e);
      testsRun++; if (cyc !== n + NUM_REGS + 1) begin testsFailed++; $display("[TB] FAIL rand%0d_len: got %0d want %0d", it, cyc, n + NUM_REGS + 1); end
      testsRun++; if (bus.err_count !== CNT_W'(errs)) begin testsFailed++; $display("[TB] FAIL rand%0d_err: got %0d want %0d", it, bus.err_count, errs); end
      testsRun++; if (bus.pass !== (errs == 0)) begin testsFailed++; $display("[TB] FAIL rand%0d_pass: got %b want %b", it, bus.pass, errs == 0); end
      testsRun++; if (bus.rs1_out !== bus.cpu_rs1) begin testsFailed++; $display("[TB] FAIL rand%0d_rs1: got %0d want %0d", it, bus.rs1_out, bus.cpu_rs1); end
      testsRun++; if (bus.first_err_valid !== v || bus.first_err_reg !== r || bus.first_err_act !== a || bus.first_err_exp !== e) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_first: got %b/%0d/%0h/%0h want %b/%0d/%0h/%0h", it,
                 bus.first_err_valid, bus.first_err_reg, bus.first_err_act, bus.first_err_exp, v, r, a, e);
      end
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.num_cycles = '0;
    bus.cpu_rs1    = '0;
    fillMatching();
    test_reset();
    test_all_match();
    test_two_errors();
    test_zero_cycles();
    test_reset_mid_scan();
    test_start_handling();
    test_last_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
